image_background_sequencer: RTL
===============================

Name: image_background_sequencer

Overview:
Frame-level controller for the background generator. It holds a 4-entry program of (operation, color) slots and issues one external frame request per interval. It steps through the enabled slots frame by frame and keeps operation/color stable for the whole frame. It sits upstream of the generator's operation, color and out_request_external inputs and monitors its out_sending output.

Parameters:
IntervalWidth, 24, width of frame interval counter and cfg_interval
FrameCountWidth, 16, width of frame_count (wraps)
TimeoutCycles, 2000000, watchdog limit in clocks (optional feature only)

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
enable  input  1  level; 1 = run sequence, 0 = stop after current frame
cfg_write  input  1  write strobe for slot table
cfg_address  input  2  slot index
cfg_operation  input  2  slot operation code
cfg_color  input  24  slot color, {B,G,R} 8 bits each
cfg_slot_enable  input  1  slot participates in sequence
cfg_interval  input  IntervalWidth  clocks from one frame request to the next request; 0 = back-to-back
gen_sending  input  1  generator busy (out_sending)
operation  output  2  to generator
color  output  24  to generator
out_request_external  output  1  single-cycle request pulse to generator
slot  output  2  slot index of current/last frame
frame_count  output  FrameCountWidth  completed frames
busy  output  1  state != IDLE
timeout_error  output  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset values: operation 0, color 0, out_request_external 0, slot 3 (so the first search starts at 0), frame_count 0, busy 0, timeout_error 0. Slot table clears to operation 0, color 0, enable 0. Interval counter is 0.
- Slot table writes take effect on the clock edge; they are allowed in any state. operation/color outputs change only in the REQUEST state, never mid-frame.
- Next-slot search: circular from slot+1, first entry with enable=1. If no slot is enabled, stay in IDLE / return to IDLE.
- States:
  - IDLE: busy=0. When enable=1 and at least one slot is enabled, go to REQUEST.
  - REQUEST (1 cycle): slot <= next enabled slot. operation/color <= that slot's entries. out_request_external=1 on the next cycle (registered, exactly one cycle high). Load interval counter with cfg_interval. Go to WAIT_START.
  - WAIT_START: wait for gen_sending=1, then go to WAIT_DONE. The request pulse is not repeated.
  - WAIT_DONE: on gen_sending 1->0, frame_count <= frame_count+1 (wraps at 2^FrameCountWidth-1 -> 0). If enable=0, go to IDLE. Otherwise go to WAIT_INTERVAL.
  - WAIT_INTERVAL: go to REQUEST when the interval counter reads <=1. Otherwise decrement the counter. The counter runs from REQUEST onward, so the period is measured request-to-request when the frame is shorter than the interval. If the frame is longer than the interval, the next request is issued in the cycle after completion. If enable drops here, go to IDLE.
- Latency: IDLE->request pulse = 2 clocks. Completion->next request (interval expired) = 2 clocks.
- Deasserting enable never aborts a frame in progress. Reasserting it in WAIT_DONE continues the sequence normally.
- Reset mid-frame returns to IDLE immediately. The generator's own reset/cancel handling is outside this block.
- Single enabled slot: the same slot repeats every frame.

Optional Feature:
- Macro: IMAGE_BACKGROUND_SEQUENCER_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to WAIT_START and counts in WAIT_START and WAIT_DONE. On reaching TimeoutCycles, set timeout_error (sticky until reset), increment nothing, and go to IDLE. The block stays in IDLE until enable is low for at least one cycle and then high again.
- Undefined: no watchdog logic, and timeout_error is tied to 0.

Test Plan:
- Reset, program slot0 = (op 0, color 24'h0000FF, en), enable=1, model frame of 100 clk -> one request pulse 2 clk after enable, operation=0, color=24'h0000FF, frame_count=1 after gen_sending falls.
- Slots 0,2 enabled (op0 red, op1 any), slot1 disabled, cfg_interval=500, 4 frames -> slot sequence 0,2,0,2, request pulses spaced exactly 500 clk, frame_count=4.
- cfg_interval=0, frame 64 clk -> next request pulse 2 clk after each gen_sending fall; outputs stable throughout gen_sending=1 even while rewriting the active slot.
- enable dropped mid-frame -> frame completes, frame_count increments, state IDLE, busy=0, no further pulse; no slots enabled with enable=1 -> stays IDLE.
- FrameCountWidth=2, 5 frames -> frame_count sequence 1,2,3,0,1.
- With IMAGE_BACKGROUND_SEQUENCER_TIMEOUT_EN, TimeoutCycles=50, gen_sending held 0 -> timeout_error=1 at cycle 50 after the request, IDLE, no re-request until enable toggles low then high.

Source files
------------

// File: rtl/image_background_sequencer.sv
// image_background_sequencer
// Frame-level controller for the background generator. Holds a 4-slot
// (operation, color) program, issues one frame request per interval and
// steps through the enabled slots, keeping operation/color fixed per frame.
// Optional watchdog: define IMAGE_BACKGROUND_SEQUENCER_TIMEOUT_EN.
//
// state         | meaning
// IDLE          | stopped, waiting for enable and an enabled slot
// REQUEST       | latch next slot's entries, launch request pulse
// WAIT_START    | waiting for the generator to start sending
// WAIT_DONE     | frame in progress, waiting for sending to fall
// WAIT_INTERVAL | frame done, waiting out the remaining interval
module image_background_sequencer #(
    parameter int IntervalWidth   = 24,
    parameter int FrameCountWidth = 16,
    parameter int TimeoutCycles   = 2000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       cfg_write,
    input  logic [1:0]                 cfg_address,
    input  logic [1:0]                 cfg_operation,
    input  logic [23:0]                cfg_color,
    input  logic                       cfg_slot_enable,
    input  logic [IntervalWidth-1:0]   cfg_interval,
    input  logic                       gen_sending,
    output logic [1:0]                 operation,
    output logic [23:0]                color,
    output logic                       out_request_external,
    output logic [1:0]                 slot,
    output logic [FrameCountWidth-1:0] frame_count,
    output logic                       busy,
    output logic                       timeout_error
);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_START,
        WAIT_DONE,
        WAIT_INTERVAL
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 slot_q, slot_d;
    logic [1:0]                 op_q, op_d;
    logic [23:0]                col_q, col_d;
    logic                       req_q, req_d;
    logic [IntervalWidth-1:0]   cnt_q, cnt_d;
    logic [FrameCountWidth-1:0] fc_q, fc_d;

    logic [1:0]  op_tab_q [4];
    logic [23:0] col_tab_q [4];
    logic [3:0]  en_tab_q;

    logic [1:0]  next_slot;
    logic        any_en;
    logic        wd_expire;
    logic        start_block;

    // Slot table: writes land on the clock edge regardless of state.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                op_tab_q[i]  <= 2'd0;
                col_tab_q[i] <= 24'd0;
            end
            en_tab_q <= 4'd0;
        end else if (cfg_write) begin
            op_tab_q[cfg_address]  <= cfg_operation;
            col_tab_q[cfg_address] <= cfg_color;
            en_tab_q[cfg_address]  <= cfg_slot_enable;
        end
    end

    // Circular search for the first enabled slot after the current one.
    always_comb begin
        logic [1:0] idx;
        idx       = slot_q;
        next_slot = slot_q + 2'd1;
        any_en    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = slot_q + 2'(i);
            if (!any_en && en_tab_q[idx]) begin
                any_en    = 1'b1;
                next_slot = idx;
            end
        end
    end

`ifdef IMAGE_BACKGROUND_SEQUENCER_TIMEOUT_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           tmo_q, tmo_d;
    logic           hold_q, hold_d;

    // Watchdog: restarts at each request, runs while a frame is outstanding.
    // After a timeout, starting again needs enable to be seen low once.
    always_comb begin
        wd_d      = wd_q;
        wd_expire = 1'b0;
        if (state_q == REQUEST) begin
            wd_d = '0;
        end else if (state_q == WAIT_START || state_q == WAIT_DONE) begin
            wd_d = wd_q + WdW'(1);
            if (wd_q == WdLast) begin
                wd_expire = 1'b1;
            end
        end
        tmo_d  = tmo_q | wd_expire;
        hold_d = hold_q;
        if (wd_expire) begin
            hold_d = 1'b1;
        end else if (!enable) begin
            hold_d = 1'b0;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q   <= '0;
            tmo_q  <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            tmo_q  <= tmo_d;
            hold_q <= hold_d;
        end
    end

    assign start_block   = hold_q;
    assign timeout_error = tmo_q;
`else
    assign wd_expire     = 1'b0;
    assign start_block   = 1'b0;
    assign timeout_error = 1'b0;
`endif

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        op_d    = op_q;
        col_d   = col_q;
        req_d   = 1'b0;
        fc_d    = fc_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - IntervalWidth'(1) : cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && any_en && !start_block) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (!any_en) begin
                    state_d = IDLE;
                end else begin
                    slot_d  = next_slot;
                    op_d    = op_tab_q[next_slot];
                    col_d   = col_tab_q[next_slot];
                    req_d   = 1'b1;
                    // The REQUEST cycle itself is the first clock of the period.
                    cnt_d   = (cfg_interval != '0) ? cfg_interval - IntervalWidth'(1) : '0;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (gen_sending) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!gen_sending) begin
                    fc_d = fc_q + FrameCountWidth'(1);
                    if (!enable || !any_en) begin
                        state_d = IDLE;
                    end else if (cnt_q <= IntervalWidth'(1)) begin
                        state_d = REQUEST;
                    end else begin
                        state_d = WAIT_INTERVAL;
                    end
                end
            end
            WAIT_INTERVAL: begin
                if (!enable || !any_en) begin
                    state_d = IDLE;
                end else if (cnt_q <= IntervalWidth'(1)) begin
                    state_d = REQUEST;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wd_expire) begin
            state_d = IDLE;
            fc_d    = fc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= 2'd3;
            op_q    <= 2'd0;
            col_q   <= 24'd0;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            op_q    <= op_d;
            col_q   <= col_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
        end
    end

    assign operation            = op_q;
    assign color                = col_q;
    assign out_request_external = req_q;
    assign slot                 = slot_q;
    assign frame_count          = fc_q;
    assign busy                 = (state_q != IDLE);

endmodule
